// File: rtl/router_pkg.sv
// Shared types for the router output-port receive path.
package router_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } rx_state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              last;
  } rx_entry_t;

endpackage

// File: rtl/router_sync_fifo.sv
// Single-clock FIFO; head entry read straight from register storage, zero when empty.
module router_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pushValid_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             popReady_i,
  output logic [WIDTH-1:0] headData_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush;
  logic             doPop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign doPop      = !empty_o && popReady_i;
  // A pop on the same edge frees the slot, so a push into a full FIFO is legal then.
  assign doPush     = pushValid_i && (!full_o || doPop);
  assign headData_o = empty_o ? '0 : mem_q[rdPtr_q];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, doPush} - {{AW{1'b0}}, doPop};
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/router_port_rx.sv
// Deserialises a router output port (frame/valid/bit strobes) into a byte FIFO
// with end-of-packet marking, overflow/alignment error pulses and a packet counter.
module router_port_rx
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              frameo_n,
  input  logic              valido_n,
  input  logic              dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic              err_overflow,
  output logic              err_align,
  output logic [15:0]       pkt_count
);

  rx_state_e         state_q, state_d;
  logic [BYTE_W-1:0] asm_q, asm_d;
  logic [2:0]        bitCnt_q, bitCnt_d;
  logic [BYTE_W-1:0] stage_q, stage_d;
  logic              stageValid_q, stageValid_d;
  logic              flushLast_q, flushLast_d;
  logic              frameSeenHigh_q;
  logic              errOverflow_q, errOverflow_d;
  logic              errAlign_q, errAlign_d;
  logic [15:0]       pktCount_q, pktCount_d;

  logic              sampled;
  logic              byteDone;
  logic [BYTE_W-1:0] newByte;
  logic              pushValid;
  logic              pushAccept;
  logic              popNow;
  logic              fifoFull;
  logic              fifoEmpty;
  rx_entry_t         pushEntry;
  rx_entry_t         headEntry;

  always_comb begin
    sampled       = !valido_n;
    newByte       = {dout, asm_q[BYTE_W-1:1]};
    byteDone      = (state_q == RECV) && sampled && (bitCnt_q == 3'd7);
    popNow        = !fifoEmpty && out_ready;
    state_d       = state_q;
    asm_d         = asm_q;
    bitCnt_d      = bitCnt_q;
    stage_d       = stage_q;
    stageValid_d  = stageValid_q;
    flushLast_d   = 1'b0;
    errOverflow_d = 1'b0;
    errAlign_d    = 1'b0;
    pktCount_d    = pktCount_q;
    pushValid     = 1'b0;
    pushEntry     = '{data: stage_q, last: 1'b0};

    // The final byte of an aligned packet is written one cycle after the packet closes.
    if (flushLast_q) begin
      pushValid      = 1'b1;
      pushEntry.last = 1'b1;
      stageValid_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!frameo_n && frameSeenHigh_q) begin
          state_d = RECV;
          if (sampled) begin
            asm_d    = newByte;
            bitCnt_d = 3'd1;
          end
        end
      end
      RECV: begin
        if (sampled) begin
          asm_d    = newByte;
          bitCnt_d = bitCnt_q + 3'd1;
        end
        if (byteDone) begin
          pushValid      = stageValid_q;
          pushEntry.last = 1'b0;
          stage_d        = newByte;
          stageValid_d   = 1'b1;
        end
        if (frameo_n) begin
          state_d  = IDLE;
          asm_d    = '0;
          bitCnt_d = '0;
          if (byteDone) begin
            flushLast_d = 1'b1;
          end else begin
            pushValid      = stageValid_q;
            pushEntry.last = 1'b1;
            stageValid_d   = 1'b0;
            errAlign_d     = 1'b1;
          end
        end
      end
      DROP: begin
        if (frameo_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    pushAccept = pushValid && (!fifoFull || popNow);

    // A refused write abandons the rest of the packet; only an open frame needs DROP.
    if (pushValid && !pushAccept) begin
      errOverflow_d = 1'b1;
      stageValid_d  = 1'b0;
      flushLast_d   = 1'b0;
      if (state_q == RECV && !frameo_n) begin
        state_d  = DROP;
        asm_d    = '0;
        bitCnt_d = '0;
      end
    end

    if (pushAccept && pushEntry.last) pktCount_d = pktCount_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      asm_q           <= '0;
      bitCnt_q        <= '0;
      stage_q         <= '0;
      stageValid_q    <= 1'b0;
      flushLast_q     <= 1'b0;
      frameSeenHigh_q <= 1'b0;
      errOverflow_q   <= 1'b0;
      errAlign_q      <= 1'b0;
      pktCount_q      <= '0;
    end else begin
      state_q         <= state_d;
      asm_q           <= asm_d;
      bitCnt_q        <= bitCnt_d;
      stage_q         <= stage_d;
      stageValid_q    <= stageValid_d;
      flushLast_q     <= flushLast_d;
      frameSeenHigh_q <= frameSeenHigh_q | frameo_n;
      errOverflow_q   <= errOverflow_d;
      errAlign_q      <= errAlign_d;
      pktCount_q      <= pktCount_d;
    end
  end

  router_sync_fifo #(
    .WIDTH($bits(rx_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .pushValid_i(pushAccept),
    .pushData_i (pushEntry),
    .popReady_i (out_ready),
    .headData_o (headEntry),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty)
  );

  assign out_valid    = !fifoEmpty;
  assign out_data     = headEntry.data;
  assign out_last     = headEntry.last;
  assign err_overflow = errOverflow_q;
  assign err_align    = errAlign_q;
  assign pkt_count    = pktCount_q;

endmodule

// File: tb/tb_router_port_rx.sv
// Directed self-checking bench for router_port_rx (FIFO_DEPTH=4 so overflow is reachable).
module tb_router_port_rx;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        frameo_n;
  logic        valido_n;
  logic        dout;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        err_overflow;
  logic        err_align;
  logic [15:0] pkt_count;

  logic [8:0]  rxQ[$];
  logic [8:0]  expQ[$];
  int          ovfCount = 0;
  int          alignCount = 0;
  int          testsRun = 0;
  int          testsFailed = 0;

  router_port_rx #(.FIFO_DEPTH(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .frameo_n    (frameo_n),
    .valido_n    (valido_n),
    .dout        (dout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .err_overflow(err_overflow),
    .err_align   (err_align),
    .pkt_count   (pkt_count)
  );

  always #5 clock = ~clock;

  // Inputs change just after rising edges, so the falling edge sees what the next rising edge pops.
  always @(negedge clock) begin
    if (out_valid && out_ready) rxQ.push_back({out_data, out_last});
    if (err_overflow) ovfCount++;
    if (err_align) alignCount++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic f, input logic v, input logic d);
    frameo_n = f;
    valido_n = v;
    dout     = d;
    @(posedge clock);
    #1;
  endtask

  task automatic sendPacket(input logic [63:0] bits, input int nBits, input bit gaps, input int idleAfter);
    for (int i = 0; i < nBits; i++) begin
      if (gaps && i > 0) applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus((i == nBits - 1), 1'b0, bits[i]);
    end
    for (int i = 0; i < idleAfter; i++) applyStimulus(1'b1, 1'b1, 1'b0);
  endtask

  task automatic waitEntries(input int n);
    int k;
    k = 0;
    while (rxQ.size() < n && k < 100) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      k++;
    end
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
  endtask

  task automatic checkQueue(input string tag, input int base);
    logic [31:0] got;
    checkOutput({tag, " entry count"}, rxQ.size() - base, expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      got = (base + i < rxQ.size()) ? {23'h0, rxQ[base + i]} : 32'hDEAD_BEEF;
      checkOutput($sformatf("%s entry%0d {data,last}", tag, i), got, {23'h0, expQ[i]});
    end
  endtask

  task automatic doReset();
    reset_n   = 1'b0;
    frameo_n  = 1'b1;
    valido_n  = 1'b1;
    dout      = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0);
  endtask

  task automatic runOverflow(input string tag, input logic [63:0] bits, input int nBytes,
                             input logic [7:0] nextByte, input int pktBefore);
    int base, ovfBase, alignBase;
    base      = rxQ.size();
    ovfBase   = ovfCount;
    alignBase = alignCount;
    out_ready = 1'b0;
    sendPacket(bits, nBytes * 8, 1'b0, 4);
    checkOutput({tag, " nothing popped"}, rxQ.size() - base, 0);
    checkOutput({tag, " out_valid held"}, out_valid, 1);
    checkOutput({tag, " head data"}, out_data, bits[7:0]);
    checkOutput({tag, " head last"}, out_last, 0);
    checkOutput({tag, " overflow pulses"}, ovfCount - ovfBase, 1);
    checkOutput({tag, " align pulses"}, alignCount - alignBase, 0);
    checkOutput({tag, " pkt_count"}, pkt_count, pktBefore);
    out_ready = 1'b1;
    expQ.delete();
    for (int i = 0; i < 4; i++) expQ.push_back({bits[8*i +: 8], 1'b0});
    waitEntries(base + 4);
    checkQueue({tag, " drain"}, base);
    base = rxQ.size();
    expQ.delete();
    expQ.push_back({nextByte, 1'b1});
    sendPacket({56'h0, nextByte}, 8, 1'b0, 2);
    waitEntries(base + 1);
    checkQueue({tag, " next packet"}, base);
    checkOutput({tag, " next pkt_count"}, pkt_count, pktBefore + 1);
  endtask

  initial begin
    int base, ovfBase, alignBase;

    reset_n   = 1'b0;
    frameo_n  = 1'b1;
    valido_n  = 1'b1;
    dout      = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_data", out_data, 0);
    checkOutput("reset out_last", out_last, 0);
    checkOutput("reset err_overflow", err_overflow, 0);
    checkOutput("reset err_align", err_align, 0);
    checkOutput("reset pkt_count", pkt_count, 0);
    reset_n = 1'b1;
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0);

    // Three bytes, no gaps.
    base = rxQ.size(); ovfBase = ovfCount; alignBase = alignCount;
    expQ.delete();
    expQ.push_back({8'hA5, 1'b0}); expQ.push_back({8'h3C, 1'b0}); expQ.push_back({8'hFF, 1'b1});
    sendPacket(64'hFF3CA5, 24, 1'b0, 2);
    waitEntries(base + 3);
    checkQueue("plain", base);
    checkOutput("plain pkt_count", pkt_count, 1);
    checkOutput("plain overflow pulses", ovfCount - ovfBase, 0);
    checkOutput("plain align pulses", alignCount - alignBase, 0);

    // Same packet with valido_n high between every bit.
    base = rxQ.size(); ovfBase = ovfCount; alignBase = alignCount;
    sendPacket(64'hFF3CA5, 24, 1'b1, 2);
    waitEntries(base + 3);
    checkQueue("gapped", base);
    checkOutput("gapped pkt_count", pkt_count, 2);
    checkOutput("gapped overflow pulses", ovfCount - ovfBase, 0);
    checkOutput("gapped align pulses", alignCount - alignBase, 0);

    // 12 bits: byte 0x81 then four stray bits.
    base = rxQ.size(); ovfBase = ovfCount; alignBase = alignCount;
    expQ.delete();
    expQ.push_back({8'h81, 1'b1});
    sendPacket(64'hA81, 12, 1'b0, 2);
    waitEntries(base + 1);
    checkQueue("unaligned", base);
    checkOutput("unaligned align pulses", alignCount - alignBase, 1);
    checkOutput("unaligned overflow pulses", ovfCount - ovfBase, 0);
    checkOutput("unaligned pkt_count", pkt_count, 3);

    // Overflow at the closing byte, then overflow mid-packet that must sit in DROP.
    runOverflow("ovf6", 64'h665544332211, 6, 8'h77, 3);
    runOverflow("ovf8", 64'h8877665544332211, 8, 8'h78, 4);

    // Reset in the middle of a packet with an entry still queued.
    out_ready = 1'b0;
    sendPacket(64'h99, 8, 1'b0, 3);
    checkOutput("pre-reset out_valid", out_valid, 1);
    checkOutput("pre-reset pkt_count", pkt_count, 6);
    for (int i = 0; i < 13; i++) applyStimulus(1'b0, 1'b0, i[0]);
    reset_n = 1'b0;
    #1;
    checkOutput("mid-reset out_valid", out_valid, 0);
    checkOutput("mid-reset out_data", out_data, 0);
    checkOutput("mid-reset pkt_count", pkt_count, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    base = rxQ.size(); ovfBase = ovfCount; alignBase = alignCount;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, i[1]);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("stale frame ignored", rxQ.size() - base, 0);
    expQ.delete();
    expQ.push_back({8'h5A, 1'b1});
    sendPacket(64'h5A, 8, 1'b0, 2);
    waitEntries(base + 1);
    checkQueue("after reset", base);
    checkOutput("after reset pkt_count", pkt_count, 1);
    checkOutput("after reset align pulses", alignCount - alignBase, 0);
    checkOutput("after reset overflow pulses", ovfCount - ovfBase, 0);

    // Back-to-back packets: the closing bit is the single frameo_n-high cycle.
    doReset();
    base = rxQ.size(); ovfBase = ovfCount; alignBase = alignCount;
    expQ.delete();
    expQ.push_back({8'h12, 1'b0}); expQ.push_back({8'h34, 1'b1});
    expQ.push_back({8'hAB, 1'b0}); expQ.push_back({8'hCD, 1'b0}); expQ.push_back({8'hEF, 1'b1});
    sendPacket(64'h3412, 16, 1'b0, 0);
    sendPacket(64'hEFCDAB, 24, 1'b0, 2);
    waitEntries(base + 5);
    checkQueue("back-to-back", base);
    checkOutput("back-to-back pkt_count", pkt_count, 2);
    checkOutput("back-to-back align pulses", alignCount - alignBase, 0);
    checkOutput("back-to-back overflow pulses", ovfCount - ovfBase, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
